seq_multiplier_32bit: RTL and testbench

Iterative radix-2 shift-add unsigned multiplier: 32-bit × 32-bit → 64-bit product over 32 add/shift cycles. It sits directly downstream of the 32-bit carry-look-ahead adder. Each cycle it feeds the adder its running partial product and consumes the adder's sum and carry. It presents a valid/ready handshake on both operand input and product output so it can be placed in the ALU datapath beside the adders.

---
 rtl/alu_pkg.sv | 15 +
 rtl/carry_look_ahead_32bit.sv | 51 +++++
 rtl/seq_multiplier_32bit.sv | 96 +++++++++
 tb/tb_seq_multiplier_32bit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier FSM encoding and sizing constants.
package alu_pkg;

    localparam int unsigned MUL_WIDTH = 32;
    localparam int unsigned MUL_STEPS = 32;
    localparam int unsigned PROD_W    = 64;
    localparam int unsigned CNT_W     = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/carry_look_ahead_32bit.sv
// 32-bit carry-look-ahead adder: 4-bit lookahead groups chained by group generate/propagate.
module carry_look_ahead_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] s,
    output logic        c
);

    localparam int unsigned GROUPS = 8;

    logic [31:0]       g;
    logic [31:0]       p;
    logic [32:0]       cy;
    logic [GROUPS:0]   gc;
    logic [GROUPS-1:0] gg;
    logic [GROUPS-1:0] gp;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        gc    = '0;
        gg    = '0;
        gp    = '0;
        cy    = '0;
        gc[0] = cin;
        // Group-level lookahead, then carries inside each group from its group carry-in.
        for (int unsigned k = 0; k < GROUPS; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
        end
        for (int unsigned k = 0; k < GROUPS; k++) begin
            cy[4*k]   = gc[k];
            cy[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            cy[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
            cy[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                      | (p[4*k+2] & p[4*k+1] & g[4*k])
                      | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end
        cy[32] = gc[GROUPS];
    end

    assign s = p ^ cy[31:0];
    assign c = cy[32];

endmodule

// File: rtl/seq_multiplier_32bit.sv
// Radix-2 shift-add unsigned multiplier, 32x32->64 over 32 steps, valid/ready on both sides.
module seq_multiplier_32bit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int unsigned PW = 2 * WIDTH;

    mul_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [PW-1:0]    p_q, p_d;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [WIDTH-1:0] add_s;
    logic             add_c;

    carry_look_ahead_32bit u_cla (
        .a   (p_q[PW-1:WIDTH]),
        .b   (mcand_q),
        .cin (1'b0),
        .s   (add_s),
        .c   (add_c)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mcand_d = mcand_q;
        p_d     = p_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    mcand_d = a;
                    p_d     = {WIDTH'(0), b};
                    count_d = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                // Adder carry-out lands in the product MSB after the shift.
                if (p_q[0]) begin
                    p_d = {add_c, add_s, p_q[WIDTH-1:1]};
                end else begin
                    p_d = {1'b0, p_q[PW-1:1]};
                end
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(MUL_STEPS - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake flags are registered copies of the next state's decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            mcand_q     <= '0;
            p_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            mcand_q     <= mcand_d;
            p_q         <= p_d;
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= (state_d == ST_DONE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = p_q;

endmodule

// File: tb/tb_seq_multiplier_32bit.sv
// Scoreboard bench for seq_multiplier_32bit: directed corner cases plus random pairs vs 64-bit multiply.
module tb_seq_multiplier_32bit;

    typedef struct {
        logic [63:0] prod;
        int unsigned acc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] product;
    logic        out_valid;
    logic        out_ready;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cyc      = 0;
    int          rdy_mode = 0;
    exp_t        sb[$];

    logic prev_ov      = 1'b0;
    logic post_handoff = 1'b0;

    seq_multiplier_32bit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .product   (product),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Consumer: 0 = always ready, 1 = random ready, 2 = stalled
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Monitor: latency on out_valid rise, product on handoff, IDLE right after handoff
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov      = 1'b0;
            post_handoff = 1'b0;
        end else begin
            if (post_handoff) begin
                check("idle_after_handoff", {62'd0, in_ready, out_valid}, 64'd2);
                post_handoff = 1'b0;
            end
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) check("unexpected_valid", 64'd1, 64'd0);
                else check("latency", 64'(cyc - sb[0].acc), 64'd32);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_handoff", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("product", product, e.prod);
                end
                post_handoff = 1'b1;
            end
            prev_ov = out_valid;
        end
    end

    // Called after a posedge; returns at posedge+1 after the accept edge.
    task automatic send(input logic [31:0] x, input logic [31:0] y);
        int n;
        n = 0;
        a = x;
        b = y;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        sb.push_back('{prod: 64'(x) * 64'(y), acc: cyc + 1});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || !in_ready || out_valid) && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (n >= 300) check("drain_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        a         = '0;
        b         = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_product", product, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic and arithmetic corners
        send(32'd3, 32'd5);
        drain();
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();
        send(32'h0, 32'hDEAD_BEEF);
        drain();
        send(32'h8000_0000, 32'd2);
        drain();

        // Backpressure: result held, new operands refused
        rdy_mode = 2;
        @(posedge clk);
        #1;
        send(32'h0001_0000, 32'h0001_0000);
        begin
            int n;
            n = 0;
            while (!out_valid && n < 60) begin
                @(negedge clk);
                n++;
            end
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            a = $urandom;
            b = $urandom;
            in_valid = 1'b1;
            @(negedge clk);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_product", product, 64'h0000_0001_0000_0000);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rdy_mode = 0;
        drain();

        // Busy ignore: 7x7 waits until the first product is gone
        send(32'h1234_5678, 32'h9ABC_DEF0);
        a = 32'd7;
        b = 32'd7;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("busy_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        send(32'd7, 32'd7);
        drain();

        // Asynchronous reset in the middle of CALC
        send(32'hCAFE_F00D, 32'h1357_9BDF);
        repeat (15) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_product", product, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) check("arst_no_valid", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(32'd6, 32'd9);
        drain();

        // Random pairs under random backpressure
        rdy_mode = 1;
        for (int i = 0; i < 200; i++) begin
            int gap;
            logic [31:0] x, y;
            gap = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
            x = $urandom;
            y = $urandom;
            if (i % 50 == 0) x = 32'hFFFF_FFFF;
            send(x, y);
        end
        drain();
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
